// File: rtl/lifo_stack.sv
// lifo_stack: synchronous LIFO of DEPTH words with a registered read port.
// sp counts occupancy (0..DEPTH). All reads and writes are addressed through sp.
// Memory contents survive reset. Stale words cannot be reached because sp governs every access.
module lifo_stack #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int SPW = $clog2(DEPTH) + 1;
   localparam int AW  = $clog2(DEPTH);

   logic [SPW-1:0]        sp_q, sp_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]         wr_idx;
   logic [AW-1:0]         top_idx;

   // Flags decode straight from the pointer register; no input reaches an output.
   assign full    = (sp_q == SPW'(DEPTH));
   assign empty   = (sp_q == '0);
   assign dout    = dout_q;
   assign wr_idx  = sp_q[AW-1:0];
   assign top_idx = AW'(sp_q - 1'b1);

   // Next-state selection for pointer, read register and storage.
   // Simultaneous push and pop on an empty stack falls through to the push-only branch.
   always_comb begin
      sp_d   = sp_q;
      dout_d = dout_q;
      mem_d  = mem_q;
      if (push && pop && !empty) begin
         dout_d         = mem_q[top_idx];
         mem_d[top_idx] = din;
      end else if (push && !full) begin
         mem_d[wr_idx] = din;
         sp_d          = sp_q + 1'b1;
      end else if (pop && !push && !empty) begin
         dout_d = mem_q[top_idx];
         sp_d   = sp_q - 1'b1;
      end
   end

   // Pointer and read register; reset takes priority over both strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q   <= '0;
         dout_q <= '0;
      end else begin
         sp_q   <= sp_d;
         dout_q <= dout_d;
      end
   end

   // Storage array; it is intentionally left out of reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed vectors for lifo_stack.
// A queue-based reference model is checked against the DUT on every falling edge.
// Hand-computed literal expectations pin both the model and the DUT.
module tb_lifo_stack;

   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          full;
   logic          empty;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Reference model state
   logic [DW-1:0] m_q [$];
   logic [DW-1:0] m_dout;
   bit            m_valid = 1'b0;

   lifo_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  (din),
      .dout (dout),
      .full (full),
      .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the stack is a queue whose back is the top of stack.
   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_dout = '0;
         m_valid = 1'b1;
      end else if (push && pop) begin
         if (m_q.size() > 0) begin
            m_dout = m_q[$];
            m_q[$] = din;
         end else begin
            m_q.push_back(din);
         end
      end else if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(din);
      end else if (pop) begin
         if (m_q.size() > 0) m_dout = m_q.pop_back();
      end
   end

   // Compare the DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_dout", {24'd0, dout}, {24'd0, m_dout});
         chk("model_full", {31'd0, full}, {31'd0, (m_q.size() == DEPTH)});
         chk("model_empty", {31'd0, empty}, {31'd0, (m_q.size() == 0)});
      end
   end

   // Apply one cycle of stimulus, then sample 1 time unit after the rising edge.
   task automatic step(input logic r, input logic pu, input logic po, input logic [DW-1:0] d);
      @(negedge clk);
      rst  = r;
      push = pu;
      pop  = po;
      din  = d;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic do_push(input logic [DW-1:0] d);
      step(1'b0, 1'b1, 1'b0, d);
   endtask

   task automatic do_pop(input logic [DW-1:0] exp_dout, input string name);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk(name, {24'd0, dout}, {24'd0, exp_dout});
   endtask

   initial begin
      // Reset
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("rst_dout", {24'd0, dout}, 32'h00);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);

      // Basic ordering
      do_push(8'hA1);
      chk("push1_empty", {31'd0, empty}, 32'd0);
      do_push(8'hB2);
      do_push(8'hC3);
      chk("push3_empty", {31'd0, empty}, 32'd0);
      do_pop(8'hC3, "pop_c3");
      do_pop(8'hB2, "pop_b2");
      do_pop(8'hA1, "pop_a1");
      chk("order_empty", {31'd0, empty}, 32'd1);
      do_push(8'hD4);
      do_push(8'hE5);
      do_pop(8'hE5, "pop_e5");
      do_pop(8'hD4, "pop_d4");
      chk("order2_empty", {31'd0, empty}, 32'd1);

      // Fill and overflow
      for (int i = 1; i <= DEPTH; i++) begin
         chk("fill_notfull", {31'd0, full}, 32'd0);
         do_push(DW'(i));
      end
      chk("fill_full", {31'd0, full}, 32'd1);
      do_push(8'h09);
      chk("ovf_full", {31'd0, full}, 32'd1);
      for (int i = DEPTH; i >= 1; i--) begin
         do_pop(DW'(i), "drain");
      end
      chk("drain_empty", {31'd0, empty}, 32'd1);

      // Underflow: set dout to 3C first
      do_push(8'h3C);
      do_pop(8'h3C, "pop_3c");
      for (int i = 0; i < 3; i++) begin
         do_pop(8'h3C, "udf_hold");
         chk("udf_empty", {31'd0, empty}, 32'd1);
      end
      do_push(8'h55);
      chk("udf_push_empty", {31'd0, empty}, 32'd0);
      do_pop(8'h55, "pop_55");

      // Simultaneous push and pop
      do_push(8'h11);
      do_push(8'h22);
      step(1'b0, 1'b1, 1'b1, 8'h99);
      chk("swap_dout", {24'd0, dout}, 32'h22);
      do_pop(8'h99, "pop_99");
      do_pop(8'h11, "pop_11");
      chk("swap_empty", {31'd0, empty}, 32'd1);
      step(1'b0, 1'b1, 1'b1, 8'h77);
      chk("emptyswap_dout", {24'd0, dout}, 32'h11);
      chk("emptyswap_empty", {31'd0, empty}, 32'd0);
      do_pop(8'h77, "pop_77");

      // Swap while full replaces the top
      for (int i = 0; i < DEPTH; i++) do_push(8'hF0 + DW'(i));
      step(1'b0, 1'b1, 1'b1, 8'h5A);
      chk("fullswap_dout", {24'd0, dout}, 32'hF7);
      chk("fullswap_full", {31'd0, full}, 32'd1);
      do_pop(8'h5A, "pop_5a");

      // Reset mid-operation with push asserted
      step(1'b1, 1'b0, 1'b0, 8'h00);
      do_push(8'h01);
      do_push(8'h02);
      do_push(8'h03);
      step(1'b1, 1'b1, 1'b0, 8'hAA);
      chk("mrst_dout", {24'd0, dout}, 32'h00);
      chk("mrst_empty", {31'd0, empty}, 32'd1);
      chk("mrst_full", {31'd0, full}, 32'd0);
      do_pop(8'h00, "mrst_pop");
      chk("mrst_pop_empty", {31'd0, empty}, 32'd1);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
